// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// txd and tx_done are registered; tx_done marks the final cycle of the stop bit.
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       uclk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       txd,
  output logic       tx_done
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             wrap;

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    wrap    = (baud_q == CNT_MAX);

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        if (tx_en) begin
          shift_d = tx_data;
          state_d = START;
        end
      end
      START: begin
        if (wrap) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered line
    // changes on the same edge that enters each bit.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[idx_d];
      default: txd_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (baud_d == CNT_MAX);
  end

  assign txd     = txd_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line-level model predicts txd/tx_done every cycle from
// the frame layout, and a mid-bit receiver reassembles each byte.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 115_200;
  localparam int BPS      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * BPS;

  logic       uclk    = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tx_en   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  always #10 uclk = ~uclk;

  uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .uclk   (uclk),
    .rst_n  (rst_n),
    .tx_data(tx_data),
    .tx_en  (tx_en),
    .txd    (txd),
    .tx_done(tx_done)
  );

  // Line level of bit position pos (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic line_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return d[pos-1];
  endfunction

  task automatic chk1(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk1({tag, " txd"}, txd, 1'b1);
      chk1({tag, " tx_done"}, tx_done, 1'b0);
      @(negedge uclk);
    end
  endtask

  // Requests a frame of d at the current negedge and checks every cycle of it,
  // then the first idle cycle. repulse_at >= 0 re-asserts tx_en with other data
  // in that frame cycle; hold keeps tx_en high throughout.
  task automatic run_frame(input logic [7:0] d, input int repulse_at,
                           input bit hold, input string tag);
    logic [7:0] rx;
    logic       stop_s;
    int         done_cnt;
    rx       = 8'h00;
    stop_s   = 1'b0;
    done_cnt = 0;
    tx_data  = d;
    tx_en    = 1'b1;
    @(negedge uclk);
    if (!hold) tx_en = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      chk1({tag, " txd"}, txd, line_bit(d, i / BPS));
      chk1({tag, " tx_done"}, tx_done, (i == FRAME - 1));
      if (tx_done) done_cnt++;
      if (i % BPS == BPS / 2) begin
        if (i / BPS >= 1 && i / BPS <= 8) rx[i/BPS-1] = txd;
        if (i / BPS == 9) stop_s = txd;
      end
      if (i == repulse_at) begin
        tx_en   = 1'b1;
        tx_data = ~d;
      end else if (!hold) begin
        tx_en = 1'b0;
      end
      @(negedge uclk);
    end
    if (!hold) tx_en = 1'b0;
    chk8({tag, " rx_byte"}, rx, d);
    chk1({tag, " stop_bit"}, stop_s, 1'b1);
    chk_int({tag, " done_count"}, done_cnt, 1);
    chk1({tag, " gap txd"}, txd, 1'b1);
    chk1({tag, " gap tx_done"}, tx_done, 1'b0);
  endtask

  initial begin
    logic [7:0] pat [3];
    pat[0] = 8'hA5;
    pat[1] = 8'h00;
    pat[2] = 8'hFF;

    // Reset held for 200 ns
    rst_n = 1'b0;
    repeat (9) begin
      @(negedge uclk);
      chk1("reset txd", txd, 1'b1);
      chk1("reset tx_done", tx_done, 1'b0);
    end
    @(negedge uclk);
    rst_n = 1'b1;
    idle_check(3 * BPS, "post_reset");

    run_frame(8'h01, -1, 1'b0, "single_01");
    idle_check(5, "after_single");

    // Sweep, each request issued in the cycle after the previous tx_done
    for (int v = 1; v <= 99; v++) begin
      run_frame(8'(v), -1, 1'b0, "sweep");
    end
    idle_check(3, "after_sweep");

    for (int k = 0; k < 3; k++) begin
      run_frame(pat[k], -1, 1'b0, "pattern");
      idle_check(2, "after_pattern");
    end

    for (int k = 0; k < 8; k++) begin
      run_frame(8'($urandom_range(0, 255)), -1, 1'b0, "random");
      idle_check($urandom_range(1, 20), "random_gap");
    end

    // Mid-frame re-request with different data is ignored
    run_frame(8'h3C, 4 * BPS + 3, 1'b0, "repulse_mid");
    idle_check(3 * BPS, "no_second_mid");

    // Request during the tx_done cycle is ignored too
    run_frame(8'h96, FRAME - 1, 1'b0, "repulse_done");
    idle_check(3 * BPS, "no_second_done");

    // tx_en held high: frames repeat with a single idle cycle between them
    tx_en = 1'b1;
    run_frame(8'hC3, -1, 1'b1, "held_0");
    run_frame(8'h5E, -1, 1'b1, "held_1");
    run_frame(8'h81, -1, 1'b1, "held_2");
    tx_en = 1'b0;
    idle_check(2 * BPS, "after_held");

    // Asynchronous reset in the middle of DATA
    tx_data = 8'h00;
    tx_en   = 1'b1;
    @(negedge uclk);
    tx_en = 1'b0;
    repeat (3 * BPS + 2) @(negedge uclk);
    chk1("pre_reset data low", txd, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async reset txd", txd, 1'b1);
    chk1("async reset tx_done", tx_done, 1'b0);
    repeat (5) begin
      @(negedge uclk);
      chk1("in_reset txd", txd, 1'b1);
      chk1("in_reset tx_done", tx_done, 1'b0);
    end
    rst_n = 1'b1;
    idle_check(2 * BPS, "after_mid_reset");
    run_frame(8'h5A, -1, 1'b0, "post_reset_frame");
    idle_check(3, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
